// File: rtl/ctrl_pkg.sv
// Shared decode constants and the control bundle carried down the E/M/W pipeline.
package ctrl_pkg;

    localparam int unsigned ALU_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic             alu_src;
        logic             reg_dst;
        logic [ALU_W-1:0] alu_control;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational op/funct decoder for the Decode stage.
// CTRL_EXT_OPS_EN adds andi/ori/slti/bne; otherwise those opcodes are illegal.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned FUNCT_W = 6
) (
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output ctrl_bundle_t       ctrl,
    output logic               branch,
    output logic               branch_ne,
    output logic               jump,
    output logic               ext_zero,
    output logic               illegal
);

    always_comb begin
        ctrl      = CTRL_NOP;
        branch    = 1'b0;
        branch_ne = 1'b0;
        jump      = 1'b0;
        ext_zero  = 1'b0;
        illegal   = 1'b0;
        case (op)
            OP_W'(OP_RTYPE): begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                case (funct)
                    FUNCT_W'(FUNCT_ADD): ctrl.alu_control = ALU_ADD;
                    FUNCT_W'(FUNCT_SUB): ctrl.alu_control = ALU_SUB;
                    FUNCT_W'(FUNCT_AND): ctrl.alu_control = ALU_AND;
                    FUNCT_W'(FUNCT_OR):  ctrl.alu_control = ALU_OR;
                    FUNCT_W'(FUNCT_SLT): ctrl.alu_control = ALU_SLT;
                    default: begin
                        ctrl    = CTRL_NOP;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_W'(OP_LW): begin
                ctrl.reg_write   = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            OP_W'(OP_SW): begin
                ctrl.mem_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            OP_W'(OP_BEQ): begin
                branch           = 1'b1;
                ctrl.alu_control = ALU_SUB;
            end
            OP_W'(OP_ADDI): begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            OP_W'(OP_J): jump = 1'b1;
`ifdef CTRL_EXT_OPS_EN
            OP_W'(OP_ANDI): begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ext_zero         = 1'b1;
                ctrl.alu_control = ALU_AND;
            end
            OP_W'(OP_ORI): begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ext_zero         = 1'b1;
                ctrl.alu_control = ALU_OR;
            end
            OP_W'(OP_SLTI): begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_SLT;
            end
            OP_W'(OP_BNE): begin
                branch_ne        = 1'b1;
                ctrl.alu_control = ALU_SUB;
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control: decode in D, control bundle carried through E/M/W with stall/flush.
// Optional extended immediates and bne via CTRL_EXT_OPS_EN.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3,
    parameter int unsigned OP_W      = 6,
    parameter int unsigned FUNCT_W   = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 stall_e,
    input  logic                 flush_e,
    output logic                 branch_d,
    output logic                 branch_ne_d,
    output logic                 jump_d,
    output logic                 ext_zero_d,
    output logic                 illegal_d,
    output logic                 reg_write_e,
    output logic                 reg_write_m,
    output logic                 reg_write_w,
    output logic                 mem_to_reg_e,
    output logic                 mem_to_reg_m,
    output logic                 mem_to_reg_w,
    output logic                 mem_write_e,
    output logic                 mem_write_m,
    output logic                 alu_src_e,
    output logic                 reg_dst_e,
    output logic [ALUCTRL_W-1:0] alu_control_e,
    output logic                 valid_e,
    output logic                 valid_m,
    output logic                 valid_w,
    output logic                 illegal_seen
);

    ctrl_bundle_t d_ctrl;
    ctrl_bundle_t e_q;
    logic         valid_e_q;
    logic         reg_write_m_q, mem_to_reg_m_q, mem_write_m_q, valid_m_q;
    logic         reg_write_w_q, mem_to_reg_w_q, valid_w_q;
    logic         illegal_seen_q;
    logic         d_advance;

    ctrl_decode #(.OP_W(OP_W), .FUNCT_W(FUNCT_W)) u_decode (
        .op        (op),
        .funct     (funct),
        .ctrl      (d_ctrl),
        .branch    (branch_d),
        .branch_ne (branch_ne_d),
        .jump      (jump_d),
        .ext_zero  (ext_zero_d),
        .illegal   (illegal_d)
    );

    assign d_advance = !stall_e && !flush_e;

    // E stage: flush beats stall; illegal instructions enter as bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q       <= CTRL_NOP;
            valid_e_q <= 1'b0;
        end else if (flush_e) begin
            e_q       <= CTRL_NOP;
            valid_e_q <= 1'b0;
        end else if (!stall_e) begin
            e_q       <= d_ctrl;
            valid_e_q <= !illegal_d;
        end
    end

    // M stage takes a bubble while E is held so the held instruction is not duplicated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            mem_write_m_q  <= 1'b0;
            valid_m_q      <= 1'b0;
        end else if (stall_e && !flush_e) begin
            reg_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            mem_write_m_q  <= 1'b0;
            valid_m_q      <= 1'b0;
        end else begin
            reg_write_m_q  <= e_q.reg_write;
            mem_to_reg_m_q <= e_q.mem_to_reg;
            mem_write_m_q  <= e_q.mem_write;
            valid_m_q      <= valid_e_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 1'b0;
            valid_w_q      <= 1'b0;
            illegal_seen_q <= 1'b0;
        end else begin
            reg_write_w_q  <= reg_write_m_q;
            mem_to_reg_w_q <= mem_to_reg_m_q;
            valid_w_q      <= valid_m_q;
            if (illegal_d && d_advance)
                illegal_seen_q <= 1'b1;
        end
    end

    assign reg_write_e   = e_q.reg_write;
    assign mem_to_reg_e  = e_q.mem_to_reg;
    assign mem_write_e   = e_q.mem_write;
    assign alu_src_e     = e_q.alu_src;
    assign reg_dst_e     = e_q.reg_dst;
    assign alu_control_e = ALUCTRL_W'(e_q.alu_control);
    assign valid_e       = valid_e_q;
    assign reg_write_m   = reg_write_m_q;
    assign mem_to_reg_m  = mem_to_reg_m_q;
    assign mem_write_m   = mem_write_m_q;
    assign valid_m       = valid_m_q;
    assign reg_write_w   = reg_write_w_q;
    assign mem_to_reg_w  = mem_to_reg_w_q;
    assign valid_w       = valid_w_q;
    assign illegal_seen  = illegal_seen_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: decode table with a W-stage scoreboard, plus stall/flush/reset sequences.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic       stall_e, flush_e;
    logic       branch_d, branch_ne_d, jump_d, ext_zero_d, illegal_d;
    logic       reg_write_e, reg_write_m, reg_write_w;
    logic       mem_to_reg_e, mem_to_reg_m, mem_to_reg_w;
    logic       mem_write_e, mem_write_m;
    logic       alu_src_e, reg_dst_e;
    logic [2:0] alu_control_e;
    logic       valid_e, valid_m, valid_w, illegal_seen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.ALUCTRL_W(3), .OP_W(6), .FUNCT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
        .stall_e(stall_e), .flush_e(flush_e),
        .branch_d(branch_d), .branch_ne_d(branch_ne_d), .jump_d(jump_d),
        .ext_zero_d(ext_zero_d), .illegal_d(illegal_d),
        .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m), .mem_to_reg_w(mem_to_reg_w),
        .mem_write_e(mem_write_e), .mem_write_m(mem_write_m),
        .alu_src_e(alu_src_e), .reg_dst_e(reg_dst_e), .alu_control_e(alu_control_e),
        .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w), .illegal_seen(illegal_seen)
    );

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       rw, m2r, mw, src, dst;
        logic [2:0] alu;
        logic       br, bne, j, ez, ill;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(input string n, input logic [5:0] o, input logic [5:0] f,
                                input logic rw, input logic m2r, input logic mw, input logic src,
                                input logic dst, input logic [2:0] alu, input logic br,
                                input logic bne, input logic j, input logic ez, input logic ill);
        vec_t v;
        v.name = n; v.op = o; v.funct = f;
        v.rw = rw; v.m2r = m2r; v.mw = mw; v.src = src; v.dst = dst; v.alu = alu;
        v.br = br; v.bne = bne; v.j = j; v.ez = ez; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic st, input logic fl);
        op = o; funct = f; stall_e = st; flush_e = fl;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(6'b000000, 6'b100000, 1'b0, 1'b0);
        #1;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t v, w;
        //       name       op         funct      rw m2r mw src dst alu     br bne j ez ill
        vecs.push_back(mk("add",  6'b000000, 6'b100000, 1, 0, 0, 0, 1, 3'b010, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sub",  6'b000000, 6'b100010, 1, 0, 0, 0, 1, 3'b110, 0, 0, 0, 0, 0));
        vecs.push_back(mk("and",  6'b000000, 6'b100100, 1, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("or",   6'b000000, 6'b100101, 1, 0, 0, 0, 1, 3'b001, 0, 0, 0, 0, 0));
        vecs.push_back(mk("slt",  6'b000000, 6'b101010, 1, 0, 0, 0, 1, 3'b111, 0, 0, 0, 0, 0));
        vecs.push_back(mk("badf", 6'b000000, 6'b000001, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1));
        vecs.push_back(mk("lw",   6'b100011, 6'b010101, 1, 1, 0, 1, 0, 3'b010, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sw",   6'b101011, 6'b111111, 0, 0, 1, 1, 0, 3'b010, 0, 0, 0, 0, 0));
        vecs.push_back(mk("beq",  6'b000100, 6'b000000, 0, 0, 0, 0, 0, 3'b110, 1, 0, 0, 0, 0));
        vecs.push_back(mk("addi", 6'b001000, 6'b100010, 1, 0, 0, 1, 0, 3'b010, 0, 0, 0, 0, 0));
        vecs.push_back(mk("j",    6'b000010, 6'b101010, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0));
        vecs.push_back(mk("op3f", 6'b111111, 6'b100000, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1));
`ifdef CTRL_EXT_OPS_EN
        vecs.push_back(mk("andi", 6'b001100, 6'b000000, 1, 0, 0, 1, 0, 3'b000, 0, 0, 0, 1, 0));
        vecs.push_back(mk("ori",  6'b001101, 6'b000000, 1, 0, 0, 1, 0, 3'b001, 0, 0, 0, 1, 0));
        vecs.push_back(mk("slti", 6'b001010, 6'b000000, 1, 0, 0, 1, 0, 3'b111, 0, 0, 0, 0, 0));
        vecs.push_back(mk("bne",  6'b000101, 6'b000000, 0, 0, 0, 0, 0, 3'b110, 0, 1, 0, 0, 0));
`else
        vecs.push_back(mk("andi", 6'b001100, 6'b000000, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1));
        vecs.push_back(mk("ori",  6'b001101, 6'b000000, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1));
        vecs.push_back(mk("slti", 6'b001010, 6'b000000, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1));
        vecs.push_back(mk("bne",  6'b000101, 6'b000000, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1));
`endif

        // Reset state
        do_reset();
        chk("rst_valid_e", 8'(valid_e), 8'd0);
        chk("rst_valid_w", 8'(valid_w), 8'd0);
        chk("rst_illegal_seen", 8'(illegal_seen), 8'd0);

        // Decode table with two drain cycles; W results checked via the scoreboard
        for (int i = 0; i < vecs.size() + 2; i++) begin
            v = (i < vecs.size()) ? vecs[i] : vecs[0];
            drive(v.op, v.funct, 1'b0, 1'b0);
            #1;
            chk({v.name, "_branch_d"},    8'(branch_d),    8'(v.br));
            chk({v.name, "_branch_ne_d"}, 8'(branch_ne_d), 8'(v.bne));
            chk({v.name, "_jump_d"},      8'(jump_d),      8'(v.j));
            chk({v.name, "_ext_zero_d"},  8'(ext_zero_d),  8'(v.ez));
            chk({v.name, "_illegal_d"},   8'(illegal_d),   8'(v.ill));
            sb.push_back(v);
            tick();
            chk({v.name, "_e_bundle"},
                8'({reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e, alu_control_e}),
                8'({v.rw, v.m2r, v.mw, v.src, v.dst, v.alu}));
            chk({v.name, "_valid_e"}, 8'(valid_e), 8'(!v.ill));
            if (sb.size() == 3) begin
                w = sb.pop_front();
                chk({w.name, "_w_stage"}, 8'({reg_write_w, mem_to_reg_w, valid_w}),
                    8'({w.rw, w.m2r, !w.ill}));
            end
        end
        chk("illegal_seen_sticky", 8'(illegal_seen), 8'd1);

        // Illegal is sticky until reset, and not recorded while stalled or flushed
        do_reset();
        chk("illegal_seen_cleared", 8'(illegal_seen), 8'd0);
        drive(6'b111111, 6'b000000, 1'b1, 1'b0);
        tick();
        drive(6'b111111, 6'b000000, 1'b0, 1'b1);
        tick();
        chk("illegal_seen_masked", 8'(illegal_seen), 8'd0);

        // Stall: add held in E, M gets bubbles, then lw advances
        drive(6'b000000, 6'b100000, 1'b0, 1'b0);
        tick();
        drive(6'b100011, 6'b000000, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall_hold_e", 8'({reg_dst_e, mem_to_reg_e, valid_e}), 8'b101);
            chk("stall_bubble_m", 8'({valid_m, reg_write_m}), 8'b00);
        end
        stall_e = 1'b0;
        tick();
        chk("stall_release_e", 8'({mem_to_reg_e, alu_src_e, reg_dst_e, valid_e}), 8'b1101);
        chk("stall_release_m", 8'({valid_m, reg_write_m}), 8'b11);

        // Flush beats stall; E empties while M still takes the old E content
        drive(6'b000100, 6'b000000, 1'b1, 1'b1);
        #1;
        chk("flush_branch_d", 8'(branch_d), 8'd1);
        tick();
        chk("flush_e_zero", 8'({valid_e, reg_write_e, alu_control_e}), 8'd0);
        chk("flush_m_takes_e", 8'({valid_m, mem_to_reg_m}), 8'b11);

        // lw then sw back to back
        drive(6'b100011, 6'b000000, 1'b0, 1'b0);
        tick();
        drive(6'b101011, 6'b000000, 1'b0, 1'b0);
        tick();
        chk("lw_m_edge2", 8'({mem_to_reg_m, mem_write_m}), 8'b10);
        drive(6'b000010, 6'b000000, 1'b0, 1'b0);
        tick();
        chk("sw_m_edge3", 8'({mem_to_reg_m, mem_write_m}), 8'b01);
        chk("lw_w_edge3", 8'({reg_write_w, mem_to_reg_w}), 8'b11);

        // Async reset mid-cycle with lw in M
        drive(6'b100011, 6'b000000, 1'b0, 1'b0);
        tick();
        tick();
        chk("pre_rst_lw_m", 8'(mem_to_reg_m), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_m", 8'({reg_write_m, mem_to_reg_m, valid_m}), 8'd0);
        chk("async_rst_e", 8'({reg_write_e, mem_to_reg_e, valid_e}), 8'd0);
        chk("async_rst_w", 8'({reg_write_w, valid_w}), 8'd0);
        tick();
        rst_n = 1'b1;
        drive(6'b000000, 6'b100000, 1'b0, 1'b0);
        tick();
        chk("post_rst_load", 8'({reg_write_e, reg_dst_e, alu_control_e, valid_e}), 8'b11_010_1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Parametrised pipelined successor to the single-cycle MIPS controller.
- Decodes op/funct in the Decode stage.
- Carries the control bundle through E/M/W pipeline registers, with stall and flush support.
- Flags illegal opcodes.
- Sits beside the datapath; hazard unit drives stall_e/flush_e, datapath consumes the per-stage controls.

Parameters:
ALUCTRL_W, 3, width of ALU control field (values per decode table, zero-extended if wider; must be >=3)
OP_W, 6, opcode width
FUNCT_W, 6, funct width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
op  in  OP_W  opcode of instruction in D
funct  in  FUNCT_W  funct field of instruction in D
stall_e  in  1  hold E register contents
flush_e  in  1  insert bubble into E
branch_d  out  1  beq in D (combinational)
branch_ne_d  out  1  bne in D (combinational; 0 without macro)
jump_d  out  1  j in D (combinational)
ext_zero_d  out  1  zero-extend immediate (combinational; 0 without macro)
illegal_d  out  1  D opcode/funct not decodable (combinational)
reg_write_e/m/w  out  1 each  register write enable per stage
mem_to_reg_e/m/w  out  1 each  load result select per stage
mem_write_e/m  out  1 each  data memory write per stage
alu_src_e  out  1  immediate operand select
reg_dst_e  out  1  rd (1) vs rt (0)
alu_control_e  out  ALUCTRL_W  ALU operation
valid_e/m/w  out  1 each  stage holds a real (non-bubble) instruction
illegal_seen  out  1  sticky illegal flag

Behaviour:
- Reset (rst_n low, async): all E/M/W registers, valid bits and illegal_seen clear to 0 immediately; D outputs remain combinational from op/funct.
- Decode (combinational):
  - R-type op 000000: reg_write=1, reg_dst=1. funct 100000 add->010, 100010 sub->110, 100100 and->000, 100101 or->001, 101010 slt->111.
  - lw 100011: reg_write, mem_to_reg, alu_src, alu=010.
  - sw 101011: mem_write, alu_src, alu=010.
  - beq 000100: branch, alu=110.
  - addi 001000: reg_write, alu_src, alu=010.
  - j 000010: jump only.
  - Any other op, or unlisted R-type funct: every control 0, illegal_d=1. X on funct treated as don't-care for non-R ops.
- E register update, per rising edge, priority order:
  1. flush_e: load all-zero bundle, valid_e=0.
  2. else stall_e: hold E.
  3. else: load D bundle, valid_e=~illegal_d.
  - flush_e wins over a simultaneous stall_e.
- M update: loads E every cycle. If stall_e=1 and flush_e=0, M loads a bubble (zero bundle, valid_m=0) so the held instruction is not duplicated.
- W update: loads M every cycle.
- Latency: D decode visible at E after 1 edge, M after 2, W after 3.
- illegal_seen: set on any edge where illegal_d=1, stall_e=0 and flush_e=0; cleared only by reset.
- Illegal instructions enter E as bubbles; no side-effect controls propagate.
- Reset asserted mid-flight discards all in-flight controls; first edge after deassert loads D normally.

Optional Feature:
CTRL_EXT_OPS_EN defined, adds:
- andi 001100: reg_write, alu_src, ext_zero, alu=000.
- ori 001101: reg_write, alu_src, ext_zero, alu=001.
- slti 001010: reg_write, alu_src, alu=111.
- bne 000101: branch_ne, alu=110.

CTRL_EXT_OPS_EN undefined: these four opcodes decode as illegal; ext_zero_d and branch_ne_d tied 0.

Decomposition:
- ctrl_pkg: opcode/funct localparams, ALU control codes, packed struct ctrl_bundle_t (reg_write, mem_to_reg, mem_write, alu_src, reg_dst, alu_control), CTRL_NOP constant.
- One combinational sub-module ctrl_decode (op, funct -> ctrl_bundle_t + branch/jump/illegal); pipe_ctrl_unit instantiates it and owns the pipeline registers.

Test Plan:
1. Reset, then op=000000 funct=100000 for one cycle -> next edge: reg_write_e=1, reg_dst_e=1, alu_control_e=010, valid_e=1; two edges later reg_write_w=1.
2. lw (100011) then sw (101011) back-to-back -> mem_to_reg_m=1 at edge 2, mem_write_m=1 at edge 3, mem_write_w absent/unaffected.
3. lw in D with stall_e=1 for 2 cycles -> E holds prior instruction, valid_m=0 for those 2 edges, then lw reaches E.
4. flush_e=1 together with stall_e=1 on beq -> E all zero, valid_e=0; branch_d=1 combinationally during D.
5. op=111111 -> illegal_d=1, valid_e=0, illegal_seen=1 after the edge and stays 1 until rst_n low.
6. With CTRL_EXT_OPS_EN: ori (001101) -> ext_zero_d=1, alu_control_e=001. Without the macro: illegal_d=1.
7. Assert rst_n low between edges with lw in M -> all stage outputs 0 immediately, without waiting for a clock edge.
